sm83_bus_ctrl: RTL and testbench
================================

Name: sm83_bus_ctrl

Overview:
Parametrised SM83 external bus interface that owns T-state generation rather than consuming externally supplied T-phases.
- Sequences memory read and write M-cycles and latches address, write data, read data and the opcode register.
- Inserts wait states on a slow-device request and tells the core sequencer to hold.
- Sits between the CPU core sequencer/datapath and the external/system bus.

Parameters:
ADR_WIDTH, 16, address bus width
WORD_SIZE, 8, data bus and opcode width
WAIT_MAX, 7, maximum wait states per M-cycle before forced release (1..255)
WCNT_W, $clog2(WAIT_MAX+1), wait counter width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
mread  in  1  request read sequence for the next M-cycle; valid only at T4
mwrite  in  1  request write sequence for the next M-cycle; valid only at T4
t1,t2,t3,t4  out  1 each  one-hot T-phase
stall  out  1  core must hold all state this clock (wait state)
ain  in  ADR_WIDTH  address from core
al_we  in  1  address latch write enable
aout  out  ADR_WIDTH  latched bus address
din  in  WORD_SIZE  write data from core
dl_we  in  1  data latch write enable, sampled on negedge clk
ext_dout  out  WORD_SIZE  data driven to bus
ext_doe  out  1  bus data output enable
ext_din  in  WORD_SIZE  data from bus
ext_wait  in  1  slow-device wait request
ext_data_lh  out  1  read data latch strobe
n_rd,p_rd,n_wr,p_wr  out  1 each  bus strobes
dout  out  WORD_SIZE  read data to core
opcode  out  WORD_SIZE  instruction register
bank_cb  out  1  CB-prefix bank flag
ctl_ir_we, ctl_ir_bank_we, ctl_ir_bank_cb_set, ctl_zero_data_oe  in  1 each  core controls
wait_cnt  out  WCNT_W  wait states inserted in the current M-cycle

Behaviour:
Reset:
- Phase goes to T4; rd_seq = wr_seq = 0; wait_cnt = 0; opcode = 0; bank_cb = 0; stall = 0.
- Strobes go to idle: n_rd = p_rd = 1; n_wr = p_wr = ext_data_lh = ext_doe = 0.
- aout, ext_dout and the read-data latch are not reset.

Phase generation:
- Phase advances T1→T2→T3→T4→T1 each clk.
- Phase holds at T3 when all of the following are true: rd_seq or wr_seq is set, ext_wait = 1, and wait_cnt < WAIT_MAX. stall = 1 combinationally during that clock.
- wait_cnt increments on each held clock and clears on leaving T4.
- When wait_cnt == WAIT_MAX, phase advances even if ext_wait = 1 (forced release).
- In an idle M-cycle, ext_wait is ignored.

Sequences:
- At T4 (when not stalled), rd_seq and wr_seq clear; then rd_seq |= mread and wr_seq |= mwrite.
- mread and mwrite both high in the same clock is illegal; the bench asserts this.

Strobes during a read sequence:
- ext_data_lh = t3, including during wait states.

Strobes during a write sequence (suppressed while reset is high):
- n_rd = 0; p_rd = t4; n_wr = t3; p_wr = t2|t3. These are held steady through wait states.
- ext_doe = 1 for the whole sequence.

Address and data latches:
- aout <= ain on posedge when al_we = 1 and stall = 0.
- ext_dout <= din on negedge when dl_we = 1.

Read data path:
- Priority for dout: ctl_zero_data_oe → 0; then rd_seq&&t4 → ext_din; otherwise the registered latch.
- The latch loads when rd_seq&&t4.

Opcode register:
- opcode = ctl_ir_we ? dout : opcode_r. opcode_r loads when ctl_ir_we (legal only when rd_seq&&t4).
- bank_cb <= ctl_ir_bank_cb_set when ctl_ir_bank_we.

Reset mid-sequence:
- Strobes return to idle immediately (combinational), and the next state equals the reset state.

Optional Feature:
SM83_BUS_WAIT_EN
- Defined: wait-state logic as described above.
- Undefined: ext_wait is ignored; stall = 0; wait_cnt is tied to 0; phase free-runs. The counter is not synthesised.

Decomposition:
- Package sm83_bus_pkg holds:
  - typedef enum t_phase_e {T1,T2,T3,T4}
  - typedef enum bus_seq_e {SEQ_IDLE,SEQ_RD,SEQ_WR}
  - strobe idle-value constants.
- Sub-module sm83_phase_gen holds the phase counter, hold logic, wait counter and stall. It takes reset, seq_active and ext_wait.

Test Plan:
- Reset, then idle for 8 clk → t1..t4 cycle with period 4; strobes at idle; stall = 0; opcode = 0.
- mread at T4, ain = 0x1234, al_we, ext_din = 0xA5, ctl_ir_we at next T4 → aout = 0x1234; ext_data_lh high in T3; dout = 0xA5; opcode = 0xA5 and held after.
- mwrite at T4, din = 0x3C with dl_we → n_rd = 0 for the whole M-cycle; p_wr high at T2 and T3; n_wr at T3; p_rd at T4; ext_dout = 0x3C; ext_doe = 1.
- Read with ext_wait high for 3 clks in T3 → T3 lasts 4 clks; stall = 1 for 3 clks; wait_cnt = 3; dout captured at the delayed T4.
- ext_wait stuck high, WAIT_MAX = 7 → exactly 7 stall clks, then forced advance to T4; wait_cnt clears at T1.
- Reset asserted during a write at T3 → n_rd = p_rd = 1 and n_wr = p_wr = ext_doe = 0 in the same clk; next phase is T4; ctl_zero_data_oe forces dout = 0 over ext_din = 0xFF.

Source files
------------

// File: rtl/sm83_bus_pkg.sv
// Shared types and constants for the SM83 external bus controller.
//   t_phase_e    : T-state encoding, one value per clock of an M-cycle
//   bus_seq_e    : bus sequence latched at T4 for the following M-cycle
//   bus_strobe_t : bus strobe bundle, with its idle (reset) value
package sm83_bus_pkg;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } t_phase_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RD   = 2'd1,
    SEQ_WR   = 2'd2
  } bus_seq_e;

  typedef struct packed {
    logic n_rd;
    logic p_rd;
    logic n_wr;
    logic p_wr;
    logic data_lh;
    logic doe;
  } bus_strobe_t;

  localparam logic N_RD_IDLE    = 1'b1;
  localparam logic P_RD_IDLE    = 1'b1;
  localparam logic N_WR_IDLE    = 1'b0;
  localparam logic P_WR_IDLE    = 1'b0;
  localparam logic DATA_LH_IDLE = 1'b0;
  localparam logic DOE_IDLE     = 1'b0;

  localparam bus_strobe_t STROBE_IDLE = '{
    n_rd:    N_RD_IDLE,
    p_rd:    P_RD_IDLE,
    n_wr:    N_WR_IDLE,
    p_wr:    P_WR_IDLE,
    data_lh: DATA_LH_IDLE,
    doe:     DOE_IDLE
  };

  // Free-running successor of a T-state (T4 wraps to T1).
  function automatic t_phase_e phase_next(input t_phase_e p);
    case (p)
      T1:      phase_next = T2;
      T2:      phase_next = T3;
      T3:      phase_next = T4;
      default: phase_next = T1;
    endcase
  endfunction

endpackage

// File: rtl/sm83_phase_gen.sv
// T-state generator with optional wait-state insertion.
// Build option: SM83_BUS_WAIT_EN enables the hold at T3 and the wait counter;
// without it the phase free-runs, stall is 0 and wait_cnt is tied to 0.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (phase -> T4)
//   seq_active  : a read or write sequence owns the current M-cycle
//   ext_wait    : slow-device wait request
//   phase       : current T-state
//   stall       : phase is being held at T3 this clock
//   wait_cnt    : wait states inserted in the current M-cycle
module sm83_phase_gen
  import sm83_bus_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 7,
  parameter int unsigned WCNT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seq_active,
  input  logic              ext_wait,
  output t_phase_e          phase,
  output logic              stall,
  output logic [WCNT_W-1:0] wait_cnt
);

  t_phase_e phase_q;
  t_phase_e phase_d;
  logic     hold_c;

`ifdef SM83_BUS_WAIT_EN
  logic [WCNT_W-1:0] cnt_q;
  logic [WCNT_W-1:0] cnt_d;

  // Hold T3 for a busy device until the per-M-cycle budget runs out.
  always_comb begin
    hold_c = 1'b0;
    cnt_d  = cnt_q;
    hold_c = !reset && (phase_q == T3) && seq_active && ext_wait &&
             (cnt_q < WCNT_W'(WAIT_MAX));
    if (phase_q == T4) begin
      cnt_d = '0;
    end else if (hold_c) begin
      cnt_d = cnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wait_cnt = cnt_q;
`else
  logic unused_wait;
  assign unused_wait = seq_active ^ ext_wait ^ (WAIT_MAX == 0);
  assign hold_c      = 1'b0;
  assign wait_cnt    = '0;
`endif

  // Phase next-state: advance unless held.
  always_comb begin
    phase_d = phase_q;
    if (!hold_c) begin
      phase_d = phase_next(phase_q);
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= T4;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
  assign stall = hold_c;

endmodule

// File: rtl/sm83_bus_ctrl.sv
// SM83 external bus interface: generates T-states, sequences read/write
// M-cycles, drives bus strobes and owns the address, data and opcode latches.
// Build option: SM83_BUS_WAIT_EN enables wait-state insertion (see sm83_phase_gen).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   mread, mwrite         : next M-cycle request, sampled at T4
//   t1..t4, stall         : one-hot T-state, wait-state hold for the core
//   ain, al_we, aout      : address in, latch enable, latched bus address
//   din, dl_we            : write data and its latch enable (negedge)
//   ext_dout, ext_doe     : bus write data and output enable
//   ext_din, ext_wait     : bus read data, slow-device wait request
//   ext_data_lh           : read data latch strobe
//   n_rd,p_rd,n_wr,p_wr   : bus strobes
//   dout, opcode, bank_cb : read data, instruction register, CB bank flag
//   ctl_*                 : core control inputs
//   wait_cnt              : wait states inserted in the current M-cycle
module sm83_bus_ctrl
  import sm83_bus_pkg::*;
#(
  parameter int unsigned  ADR_WIDTH = 16,
  parameter int unsigned  WORD_SIZE = 8,
  parameter int unsigned  WAIT_MAX  = 7,
  localparam int unsigned WCNT_W    = $clog2(WAIT_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mread,
  input  logic                 mwrite,
  output logic                 t1,
  output logic                 t2,
  output logic                 t3,
  output logic                 t4,
  output logic                 stall,
  input  logic [ADR_WIDTH-1:0] ain,
  input  logic                 al_we,
  output logic [ADR_WIDTH-1:0] aout,
  input  logic [WORD_SIZE-1:0] din,
  input  logic                 dl_we,
  output logic [WORD_SIZE-1:0] ext_dout,
  output logic                 ext_doe,
  input  logic [WORD_SIZE-1:0] ext_din,
  input  logic                 ext_wait,
  output logic                 ext_data_lh,
  output logic                 n_rd,
  output logic                 p_rd,
  output logic                 n_wr,
  output logic                 p_wr,
  output logic [WORD_SIZE-1:0] dout,
  output logic [WORD_SIZE-1:0] opcode,
  output logic                 bank_cb,
  input  logic                 ctl_ir_we,
  input  logic                 ctl_ir_bank_we,
  input  logic                 ctl_ir_bank_cb_set,
  input  logic                 ctl_zero_data_oe,
  output logic [WCNT_W-1:0]    wait_cnt
);

  t_phase_e             phase;
  bus_seq_e             seq_q;
  bus_seq_e             seq_d;
  bus_strobe_t          strb;
  logic                 rd_seq;
  logic                 seq_active;
  logic [WORD_SIZE-1:0] rd_latch;
  logic [WORD_SIZE-1:0] opcode_r;

  sm83_phase_gen #(
    .WAIT_MAX (WAIT_MAX),
    .WCNT_W   (WCNT_W)
  ) u_phase_gen (
    .clk        (clk),
    .reset      (reset),
    .seq_active (seq_active),
    .ext_wait   (ext_wait),
    .phase      (phase),
    .stall      (stall),
    .wait_cnt   (wait_cnt)
  );

  assign t1 = (phase == T1);
  assign t2 = (phase == T2);
  assign t3 = (phase == T3);
  assign t4 = (phase == T4);

  assign rd_seq     = (seq_q == SEQ_RD);
  assign seq_active = (seq_q != SEQ_IDLE);

  // Sequence next-state: the request present at T4 owns the next M-cycle.
  always_comb begin
    seq_d = seq_q;
    if (t4 && !stall) begin
      if (mread) begin
        seq_d = SEQ_RD;
      end else if (mwrite) begin
        seq_d = SEQ_WR;
      end else begin
        seq_d = SEQ_IDLE;
      end
    end
  end

  // Sequence register.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q <= SEQ_IDLE;
    end else begin
      seq_q <= seq_d;
    end
  end

  // Bus strobes; forced idle while reset is high, even mid-sequence.
  always_comb begin
    strb = STROBE_IDLE;
    if (!reset) begin
      case (seq_q)
        SEQ_RD: begin
          strb.data_lh = t3;
        end
        SEQ_WR: begin
          strb.n_rd = 1'b0;
          strb.p_rd = t4;
          strb.n_wr = t3;
          strb.p_wr = t2 | t3;
          strb.doe  = 1'b1;
        end
        default: begin
          strb = STROBE_IDLE;
        end
      endcase
    end
  end

  assign n_rd        = strb.n_rd;
  assign p_rd        = strb.p_rd;
  assign n_wr        = strb.n_wr;
  assign p_wr        = strb.p_wr;
  assign ext_data_lh = strb.data_lh;
  assign ext_doe     = strb.doe;

  // Address and read-data latches carry no reset value.
  always_ff @(posedge clk) begin
    if (al_we && !stall) begin
      aout <= ain;
    end
    if (rd_seq && t4) begin
      rd_latch <= ext_din;
    end
  end

  // Write data is captured mid-cycle so the core can present it late.
  always_ff @(negedge clk) begin
    if (dl_we) begin
      ext_dout <= din;
    end
  end

  // Read data is bypassed from the bus during the capturing T4.
  always_comb begin
    dout = rd_latch;
    if (ctl_zero_data_oe) begin
      dout = '0;
    end else if (rd_seq && t4) begin
      dout = ext_din;
    end
  end

  // Instruction register and CB-prefix bank flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_r <= '0;
      bank_cb  <= 1'b0;
    end else begin
      if (ctl_ir_we) begin
        opcode_r <= dout;
      end
      if (ctl_ir_bank_we) begin
        bank_cb <= ctl_ir_bank_cb_set;
      end
    end
  end

  assign opcode = ctl_ir_we ? dout : opcode_r;

endmodule

// File: tb/tb_sm83_bus_ctrl.sv
// Self-checking bench for sm83_bus_ctrl (default parameters).
module tb_sm83_bus_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          mread, mwrite;
  logic          t1, t2, t3, t4, stall;
  logic [AW-1:0] ain, aout;
  logic          al_we;
  logic [DW-1:0] din, ext_dout, ext_din, dout, opcode;
  logic          dl_we, ext_doe, ext_wait, ext_data_lh;
  logic          n_rd, p_rd, n_wr, p_wr, bank_cb;
  logic          ctl_ir_we, ctl_ir_bank_we, ctl_ir_bank_cb_set, ctl_zero_data_oe;
  logic [CW-1:0] wait_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] wr_q[$];

  always #5 clk = ~clk;

  sm83_bus_ctrl dut (
    .clk(clk), .reset(reset), .mread(mread), .mwrite(mwrite),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4), .stall(stall),
    .ain(ain), .al_we(al_we), .aout(aout),
    .din(din), .dl_we(dl_we), .ext_dout(ext_dout), .ext_doe(ext_doe),
    .ext_din(ext_din), .ext_wait(ext_wait), .ext_data_lh(ext_data_lh),
    .n_rd(n_rd), .p_rd(p_rd), .n_wr(n_wr), .p_wr(p_wr),
    .dout(dout), .opcode(opcode), .bank_cb(bank_cb),
    .ctl_ir_we(ctl_ir_we), .ctl_ir_bank_we(ctl_ir_bank_we),
    .ctl_ir_bank_cb_set(ctl_ir_bank_cb_set), .ctl_zero_data_oe(ctl_zero_data_oe),
    .wait_cnt(wait_cnt)
  );

  // Simultaneous read and write requests are illegal.
  always @(posedge clk) begin
    assert (!(mread && mwrite)) else begin
      n_fail++;
      $display("FAIL illegal_req: mread=%b mwrite=%b required not both", mread, mwrite);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [3:0] ph_exp(input int k);
    case (k % 4)
      0:       ph_exp = 4'b1000;
      1:       ph_exp = 4'b0100;
      2:       ph_exp = 4'b0010;
      default: ph_exp = 4'b0001;
    endcase
  endfunction

  task automatic wait_t4();
    int n = 0;
    while (t4 !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    n_tests++;
    if (t4 !== 1'b1) begin n_fail++; $display("FAIL wait_t4: t4=%b required 1 within 8 clk", t4); end
  endtask

  task automatic test_reset();
    logic [3:0] e;
    reset = 1'b1; mread = 0; mwrite = 0; ain = '0; al_we = 0; din = '0; dl_we = 0;
    ext_din = '0; ext_wait = 0; ctl_ir_we = 0; ctl_ir_bank_we = 0;
    ctl_ir_bank_cb_set = 0; ctl_zero_data_oe = 0;
    repeat (3) step();
    n_tests++;
    if ({t1, t2, t3, t4} !== 4'b0001) begin n_fail++; $display("FAIL reset_phase: got %b want 0001", {t1, t2, t3, t4}); end
    n_tests++;
    if ({n_rd, p_rd, n_wr, p_wr, ext_data_lh, ext_doe} !== 6'b110000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 110000", {n_rd, p_rd, n_wr, p_wr, ext_data_lh, ext_doe});
    end
    n_tests++;
    if ({stall, opcode, bank_cb, wait_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_regs: stall=%b opcode=%h bank_cb=%b wait_cnt=%0d want all 0", stall, opcode, bank_cb, wait_cnt);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      e = ph_exp(i);
      n_tests++;
      if ({t1, t2, t3, t4} !== e) begin n_fail++; $display("FAIL idle_phase[%0d]: got %b want %b", i, {t1, t2, t3, t4}, e); end
      n_tests++;
      if ({n_rd, p_rd, n_wr, p_wr, ext_data_lh, ext_doe, stall} !== 7'b1100000) begin
        n_fail++; $display("FAIL idle_strobes[%0d]: got %b want 1100000", i, {n_rd, p_rd, n_wr, p_wr, ext_data_lh, ext_doe, stall});
      end
    end
  endtask

  task automatic test_read();
    logic [DW-1:0] e;
    wait_t4();
    mread = 1; ain = 16'h1234; al_we = 1; ext_din = 8'hA5; rd_q.push_back(8'hA5);
    step();
    mread = 0; al_we = 0; ain = 16'hFFFF;
    settle();
    n_tests++;
    if (aout !== 16'h1234) begin n_fail++; $display("FAIL read_aout: got %h want 1234", aout); end
    step();
    n_tests++;
    if (ext_data_lh !== 1'b0) begin n_fail++; $display("FAIL read_lh_t2: got %b want 0", ext_data_lh); end
    step();
    n_tests++;
    if ({t3, ext_data_lh} !== 2'b11) begin n_fail++; $display("FAIL read_lh_t3: t3,lh got %b want 11", {t3, ext_data_lh}); end
    step();
    ctl_ir_we = 1; ctl_ir_bank_we = 1; ctl_ir_bank_cb_set = 1;
    settle();
    e = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hXX;
    n_tests++;
    if (dout !== e || opcode !== e) begin n_fail++; $display("FAIL read_t4: dout=%h opcode=%h want %h", dout, opcode, e); end
    step();
    ctl_ir_we = 0; ctl_ir_bank_we = 0; ctl_ir_bank_cb_set = 0; ext_din = 8'h00;
    settle();
    n_tests++;
    if (opcode !== 8'hA5 || dout !== 8'hA5 || bank_cb !== 1'b1) begin
      n_fail++; $display("FAIL read_hold: opcode=%h dout=%h bank_cb=%b want a5 a5 1", opcode, dout, bank_cb);
    end
  endtask

  task automatic test_write();
    logic [DW-1:0] e;
    logic [3:0]    ep;
    wait_t4();
    mwrite = 1; din = 8'h3C; dl_we = 1; wr_q.push_back(8'h3C);
    step();
    mwrite = 0; dl_we = 0; din = 8'h00;
    settle();
    e = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hXX;
    for (int i = 0; i < 4; i++) begin
      ep = ph_exp(i);
      n_tests++;
      if ({t1, t2, t3, t4} !== ep) begin n_fail++; $display("FAIL write_phase[%0d]: got %b want %b", i, {t1, t2, t3, t4}, ep); end
      n_tests++;
      if ({n_rd, p_rd, n_wr, p_wr, ext_doe} !== {1'b0, i == 3, i == 2, i == 1 || i == 2, 1'b1}) begin
        n_fail++; $display("FAIL write_strobes[%0d]: n_rd,p_rd,n_wr,p_wr,doe got %b want %b", i,
          {n_rd, p_rd, n_wr, p_wr, ext_doe}, {1'b0, i == 3, i == 2, i == 1 || i == 2, 1'b1});
      end
      n_tests++;
      if (ext_dout !== e) begin n_fail++; $display("FAIL write_dout[%0d]: got %h want %h", i, ext_dout, e); end
      step();
    end
    n_tests++;
    if ({n_rd, ext_doe} !== 2'b10) begin n_fail++; $display("FAIL write_end: n_rd,doe got %b want 10", {n_rd, ext_doe}); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d, e;
    wait_t4();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        e = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hXX;
        n_tests++;
        if (dout !== e) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %h want %h", k, dout, e); end
      end
      if (k < 3) begin
        d = 8'h11 * 8'(k + 1);
        mread = 1; ext_din = d; rd_q.push_back(d);
      end
      step();
      mread = 0;
      repeat (3) step();
    end
  endtask

`ifdef SM83_BUS_WAIT_EN
  task automatic run_to_t4(input bit stuck, input int n_wait, output int t3c, output int stc);
    int n = 0;
    t3c = 0; stc = 0;
    forever begin
      ext_wait = stuck || (stc < n_wait);
      settle();
      if (t3 === 1'b1) begin
        t3c++;
        n_tests++;
        if (ext_data_lh !== 1'b1) begin n_fail++; $display("FAIL wait_lh: got %b want 1 in T3", ext_data_lh); end
      end
      if (stall === 1'b1) stc++;
      if (t4 === 1'b1) break;
      if (n >= 32) begin
        n_tests++; n_fail++; $display("FAIL wait_timeout: no T4 within 32 clk");
        break;
      end
      step();
      n++;
    end
    ext_wait = 0;
  endtask

  task automatic test_wait();
    int t3c, stc;
    logic [DW-1:0] e;
    wait_t4();
    mread = 1; ext_din = 8'h5A; rd_q.push_back(8'h5A);
    step();
    mread = 0;
    run_to_t4(1'b0, 3, t3c, stc);
    n_tests++;
    if (t3c !== 4 || stc !== 3) begin n_fail++; $display("FAIL wait3_len: T3 clks=%0d stall clks=%0d want 4 3", t3c, stc); end
    n_tests++;
    if (wait_cnt !== 3'd3) begin n_fail++; $display("FAIL wait3_cnt: got %0d want 3", wait_cnt); end
    e = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hXX;
    n_tests++;
    if (dout !== e) begin n_fail++; $display("FAIL wait3_dout: got %h want %h", dout, e); end
    mread = 1; ext_din = 8'h77; rd_q.push_back(8'h77);
    step();
    mread = 0;
    n_tests++;
    if (wait_cnt !== 3'd0) begin n_fail++; $display("FAIL wait3_clear: got %0d want 0", wait_cnt); end
    run_to_t4(1'b1, 0, t3c, stc);
    n_tests++;
    if (t3c !== 8 || stc !== 7) begin n_fail++; $display("FAIL forced_len: T3 clks=%0d stall clks=%0d want 8 7", t3c, stc); end
    n_tests++;
    if (wait_cnt !== 3'd7) begin n_fail++; $display("FAIL forced_cnt: got %0d want 7", wait_cnt); end
    e = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hXX;
    n_tests++;
    if (dout !== e) begin n_fail++; $display("FAIL forced_dout: got %h want %h", dout, e); end
    ext_wait = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({t1, t2, t3, t4} !== ph_exp(i) || stall !== 1'b0 || wait_cnt !== 3'd0) begin
        n_fail++; $display("FAIL idle_wait[%0d]: phase=%b stall=%b cnt=%0d want %b 0 0", i,
          {t1, t2, t3, t4}, stall, wait_cnt, ph_exp(i));
      end
    end
    ext_wait = 0;
  endtask
`else
  task automatic test_wait();
    logic [DW-1:0] e;
    wait_t4();
    mread = 1; ext_din = 8'h5A; rd_q.push_back(8'h5A);
    step();
    mread = 0; ext_wait = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++;
      if ({t1, t2, t3, t4} !== ph_exp(i) || stall !== 1'b0 || wait_cnt !== 3'd0) begin
        n_fail++; $display("FAIL nowait[%0d]: phase=%b stall=%b cnt=%0d want %b 0 0", i,
          {t1, t2, t3, t4}, stall, wait_cnt, ph_exp(i));
      end
      step();
    end
    e = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hXX;
    n_tests++;
    if (t4 !== 1'b1 || dout !== e) begin n_fail++; $display("FAIL nowait_t4: t4=%b dout=%h want 1 %h", t4, dout, e); end
    ext_wait = 0;
  endtask
`endif

  task automatic test_reset_mid();
    wait_t4();
    mwrite = 1; din = 8'h99; dl_we = 1;
    step();
    mwrite = 0; dl_we = 0;
    step();
    step();
    settle();
    n_tests++;
    if ({t3, n_wr, n_rd} !== 3'b110) begin n_fail++; $display("FAIL mid_pre: t3,n_wr,n_rd got %b want 110", {t3, n_wr, n_rd}); end
    reset = 1;
    settle();
    n_tests++;
    if ({n_rd, p_rd, n_wr, p_wr, ext_doe, stall} !== 6'b110000) begin
      n_fail++; $display("FAIL mid_strobes: got %b want 110000", {n_rd, p_rd, n_wr, p_wr, ext_doe, stall});
    end
    ctl_zero_data_oe = 1; ext_din = 8'hFF;
    settle();
    n_tests++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL zero_oe: got %h want 00", dout); end
    step();
    n_tests++;
    if ({t1, t2, t3, t4} !== 4'b0001 || opcode !== 8'h00 || bank_cb !== 1'b0 || wait_cnt !== 3'd0) begin
      n_fail++; $display("FAIL mid_next: phase=%b opcode=%h bank_cb=%b cnt=%0d want 0001 00 0 0",
        {t1, t2, t3, t4}, opcode, bank_cb, wait_cnt);
    end
    reset = 0; ctl_zero_data_oe = 0;
    step();
    n_tests++;
    if ({t1, n_rd, ext_doe} !== 3'b110) begin n_fail++; $display("FAIL mid_after: t1,n_rd,doe got %b want 110", {t1, n_rd, ext_doe}); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_wait();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
